util_axis_1553_encoder: RTL
===========================

# util_axis_1553_encoder

Converts a 16-bit AXI-Stream word into a MIL-STD-1553 Manchester II differential bit stream at 1 Mbit/s: a 3 µs sync, 16 data bits MSB first, then an odd parity bit. It is the transmit-side counterpart of `util_axis_1553_decoder`, and its `diff` output drives the transceiver or loops back into the decoder's `diff` input. A one-deep holding register allows words to be sent back-to-back with no idle cycles.

## Interface
- `clock_speed`, default 100000000: `aclk` frequency in Hz. Must be an integer multiple of 2000000.
- `gap_bits`, default 0: forced bus-idle time inserted after every word, in 1 µs bit-times. 0 means contiguous words.
- `aclk` input, 1 bit: clock. One clock only.
- `arstn` input, 1 bit: reset, synchronous and active-low.
- `s_axis_tdata` input, 16 bits: word to transmit. Bit 15 is sent first.
- `s_axis_tvalid` input, 1 bit: AXI-S valid.
- `s_axis_tuser` input, 8 bits: per-word control.
  - [0]: 1 selects command/status sync, 0 selects data sync.
  - [1]: 1 inverts the parity bit, for error injection.
  - [7:2]: reserved and ignored.
- `s_axis_tready` output, 1 bit: AXI-S ready. Registered.
- `diff` output, 2 bits: differential line pair. During a word `diff[1] = ~diff[0]`. `2'b00` is bus idle.

## Operation
- Half-bit period: H = clock_speed/2000000 cycles (50 at 100 MHz). A word lasts 40·H cycles.
- Line encoding on `diff[0]`:
  - Command/status sync: low for 3H, then high for 3H.
  - Data sync: high for 3H, then low for 3H.
  - Logic 1: low for H, then high for H.
  - Logic 0: high for H, then low for H.
  - Parity bit: `~^tdata`, XORed with `tuser[1]`.
- Datapath:
  - The holding register captures tdata/tuser on a handshake.
  - The shift engine loads from the holding register when it is idle, or in the cycle after its final half-bit.
- `s_axis_tready` = 1 exactly when the holding register is empty. It is registered, so it drops on the edge after the handshake.
- Shift engine states:
  - IDLE: `diff=00`. Go to SYNC when the holding register is full.
  - SYNC: 6 half-bits. Then go to DATA.
  - DATA: 32 half-bits, MSB first. Then go to PARITY.
  - PARITY: 2 half-bits. Then:
    - to GAP if `gap_bits>0`;
    - otherwise to SYNC if the holding register is full (load in the same cycle);
    - otherwise to IDLE.
  - GAP: `diff=00` for gap_bits·2H cycles. Then go to SYNC if the holding register is full, otherwise to IDLE.
- Counters:
  - Cycle counter runs 0..H−1 and wraps.
  - Half-bit index runs 0..39.
  - Gap counter is wide enough for gap_bits·2H.
  - No other arithmetic.
- Simultaneous load and handshake: when the engine loads from the holding register in the same cycle as a new handshake, the new word is captured. The register stays full, tready stays 0, and no word is lost or duplicated.
- tdata/tuser are sampled only at the handshake. Input changes while tready=0 have no effect.
- Reset (arstn=0 at any edge, including mid-word):
  - `diff=2'b00`, `s_axis_tready=0`, state IDLE.
  - Counters and holding register cleared; the in-flight word is discarded.
  - tready rises on the first edge with arstn=1.

## Timing
- Reset values: `s_axis_tready=0`, `diff=2'b00`.
- Latency: a handshake at edge N puts the first sync half-bit on `diff` at edge N+2.
- Contiguous mode (gap_bits=0): the next sync begins on the edge directly after the final parity half-bit, with zero `00` cycles. Word starts are exactly 40·H cycles apart.
- Gap mode: `diff=00` for exactly gap_bits·2H cycles between the final parity half-bit and the next sync.
- Throughput: one word per 40·H + gap_bits·2H cycles. The holding register allows accepting word N+1 while word N is being sent.
- `diff` changes only on H-cycle boundaries, apart from the transitions into and out of IDLE/GAP.

## Test plan
All scenarios use clock_speed = 100 MHz (H = 50) unless noted.
- **Command word:** tdata=0x0000, tuser=0x01.
  - `diff[0]`: 150 cycles 0, 150 cycles 1, 16×(50 high, 50 low), parity 1 (50 low, 50 high).
  - 2000 cycles total, then 00. `diff[1]` is always the complement.
- **Data word:** tdata=0xFFFF, tuser=0x00.
  - 150 high, 150 low, 16×(50 low, 50 high), parity 1 (50 low, 50 high).
- **Back-to-back:** 0x8001 then 0x1234 offered continuously, gap_bits=0.
  - Second sync begins exactly 2000 cycles after the first.
  - tready is 0 while the second word is held.
  - No 00 cycles between the words.
- **Parity injection:** tdata=0x0001, tuser=0x02. Parity half-bits read low-then-high (logic 1) instead of high-then-low.
- **Reset mid-word:** arstn=0 at cycle 700 of a word.
  - diff=00 and tready=0 on the next edge.
  - After release, tready=1 one edge later. The next word (0xA5A5) is encoded cleanly from sync.
- **Loopback:** gap_bits=4, ten incrementing words looped into `util_axis_1553_decoder`.
  - 400 cycles of 00 between words.
  - Decoder tdata matches each word in order, with the matching sync type flagged.

Source files
------------

// File: rtl/util_axis_1553_encoder.sv
// MIL-STD-1553 Manchester II transmitter: AXI-Stream 16-bit word in, differential pair out.
// A one-deep holding register feeds the shift engine so words can run back-to-back.
module util_axis_1553_encoder #(
  parameter int clock_speed = 100000000,
  parameter int gap_bits    = 0
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tuser,
  output logic        s_axis_tready,
  output logic [1:0]  diff
);

  localparam int H  = clock_speed / 2000000;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam int G  = gap_bits * 2 * H;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(H - 1);
  localparam logic [GW-1:0] G_LAST = (G > 0) ? GW'(G - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_idx;
  logic [GW-1:0] r_gap;
  logic [16:0]   r_shift;
  logic          r_cmd;
  logic [15:0]   r_hold_data;
  logic          r_hold_cmd;
  logic          r_hold_inv;
  logic          r_full;
  logic          r_tready;
  logic [1:0]    r_diff;

  logic w_hs;
  logic w_half_end;
  logic w_word_end;
  logic w_gap_end;
  logic w_load;
  logic w_active;
  logic w_level;
  logic w_unused_tuser;

  assign w_unused_tuser = ^s_axis_tuser[7:2];
  assign s_axis_tready  = r_tready;
  assign diff           = r_diff;

  always_comb begin
    w_hs       = s_axis_tvalid & r_tready;
    w_half_end = (r_cnt == C_LAST);
    w_word_end = (r_state == S_PARITY) && (r_idx == 6'd39) && w_half_end;
    w_gap_end  = (r_state == S_GAP) && (r_gap == G_LAST);
    w_load     = r_full && ((r_state == S_IDLE) || (w_word_end && (G == 0)) || w_gap_end);
    w_active   = (r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_PARITY);
    // Sync is 3 half-bits of one level then 3 of the other; bits send ~b then b.
    if (r_state == S_SYNC) w_level = (r_idx >= 6'd3) ^ ~r_cmd;
    else                   w_level = r_idx[0] ? r_shift[16] : ~r_shift[16];
  end

  // Holding register: tready mirrors "empty" one edge later.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_full      <= 1'b0;
      r_tready    <= 1'b0;
      r_hold_data <= '0;
      r_hold_cmd  <= 1'b0;
      r_hold_inv  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_hold_data <= s_axis_tdata;
        r_hold_cmd  <= s_axis_tuser[0];
        r_hold_inv  <= s_axis_tuser[1];
      end
      r_full   <= w_hs | (r_full & ~w_load);
      r_tready <= ~(w_hs | (r_full & ~w_load));
    end
  end

  // Shift engine: diff is registered from the current state, one cycle behind it.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_shift <= '0;
      r_cmd   <= 1'b0;
      r_diff  <= 2'b00;
    end else begin
      r_diff <= w_active ? {~w_level, w_level} : 2'b00;
      if (w_load) begin
        r_state <= S_SYNC;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_gap   <= '0;
        r_shift <= {r_hold_data, (~^r_hold_data) ^ r_hold_inv};
        r_cmd   <= r_hold_cmd;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            r_idx <= '0;
            r_gap <= '0;
          end
          S_SYNC, S_DATA, S_PARITY: begin
            if (w_half_end) begin
              r_cnt <= '0;
              r_idx <= r_idx + 6'd1;
              if ((r_state != S_SYNC) && r_idx[0]) r_shift <= {r_shift[15:0], 1'b0};
              if (r_idx == 6'd5)       r_state <= S_DATA;
              else if (r_idx == 6'd37) r_state <= S_PARITY;
              else if (r_idx == 6'd39) r_state <= (G > 0) ? S_GAP : S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (w_gap_end) begin
              r_state <= S_IDLE;
              r_gap   <= '0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
